// File: rtl/fetch_sequencer_pkg.sv
// cpu_pkg: shared fetch-sequencer types, field positions and reset default.
package cpu_pkg;
    typedef enum logic {FETCH, EXEC} fetch_state_t;
    localparam int OPCODE_W = 6;
    localparam int FUNCT_W = 6;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int JIDX_HI = 25;
    localparam int JIDX_LO = 0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory request/response handshake.
interface fetch_sequencer_if #(parameter int N = 32);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ready;
    logic [31:0]  imem_rdata;
    modport master(output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave(input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_sequencer_next_pc.sv
// next_pc_calc: next-PC priority mux (jr > jump/jal > taken branch > pc+4).
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] pc_plus4,
    input  logic [31:0]  instr,
    input  logic         branch,
    input  logic         zero,
    input  logic         jump,
    input  logic         jal,
    input  logic         jr,
    input  logic [N-1:0] jr_target,
    output logic [N-1:0] next_pc
);
    logic [N-1:0] jr_pc, j_pc, br_pc;
    logic unused_bits;
    assign jr_pc = {jr_target[N-1:2], 2'b00};
    assign j_pc = {pc_plus4[N-1:28], instr[JIDX_HI:JIDX_LO], 2'b00};
    assign br_pc = pc_plus4 + {{(N-18){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO], 2'b00};
    assign unused_bits = &{1'b0, instr[31:26], jr_target[1:0]};
    always_comb
        next_pc = jr ? jr_pc : (jump | jal) ? j_pc : (branch & zero) ? br_pc : pc_plus4;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-state fetch/execute PC sequencer feeding the decoder.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int N = 32,
    parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.master   imem,
    output logic [31:0]         instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [FUNCT_W-1:0]  funct,
    output logic                instr_valid,
    input  logic                retire,
    input  logic                branch,
    input  logic                zero,
    input  logic                jump,
    input  logic                jal,
    input  logic                jr,
    input  logic [N-1:0]        jr_target,
    output logic [N-1:0]        pc,
    output logic [N-1:0]        pc_plus4
);
    fetch_state_t state, state_n;
    logic [N-1:0] next_pc;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc <= RESET_PC;
            instr <= '0;
        end else begin
            state <= state_n;
            if (state == FETCH && imem.imem_ready) instr <= imem.imem_rdata;
            if (state == EXEC && retire) pc <= next_pc;
        end
    end
    // Request is gated by rst so memory never sees a fetch during reset.
    always_comb begin
        state_n = state;
        imem.imem_req = 1'b0;
        instr_valid = 1'b0;
        if (state == FETCH) begin
            imem.imem_req = ~rst;
            state_n = imem.imem_ready ? EXEC : FETCH;
        end else begin
            instr_valid = 1'b1;
            state_n = retire ? FETCH : EXEC;
        end
    end
    assign imem.imem_addr = pc;
    assign pc_plus4 = pc + N'(4);
    assign opcode = instr[OPC_HI:OPC_LO];
    assign funct = instr[FUNCT_HI:FUNCT_LO];
    next_pc_calc #(.N(N)) u_next_pc (
        .pc_plus4(pc_plus4),
        .instr(instr),
        .branch(branch),
        .zero(zero),
        .jump(jump),
        .jal(jal),
        .jr(jr),
        .jr_target(jr_target),
        .next_pc(next_pc)
    );
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch and PC-sequencing block for the CPU. It sits upstream of the control unit: it fetches a word from instruction memory and presents the decoder with `opcode`/`funct`. It then consumes the decoder's `branch`, `jump`, `jal`, `jr` outcome at retirement and computes the next PC. It also supplies the `jal` link value (PC+4) to the register-file write path.

## Interface
- `N`, 32, address/data width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word-aligned
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  N  fetch address (= `pc`), stable while `imem_req` is high
- `imem_ready`  in  1  memory returns `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched instruction word
- `instr`  out  32  latched instruction
- `opcode`  out  6  `instr[31:26]`, to control unit
- `funct`  out  6  `instr[5:0]`, to control unit
- `instr_valid`  out  1  `instr` is held for decode/execute
- `retire`  in  1  execute done; the control inputs below are sampled this cycle
- `branch`, `zero`, `jump`, `jal`, `jr`  in  1 each  control outcome for the current instruction
- `jr_target`  in  N  rs register value for `jr`
- `pc`  out  N  address of the current instruction
- `pc_plus4`  out  N  `pc + 4`, combinational; used as the `jal` link value

## Operation
- Two-state FSM: FETCH, EXEC.
- FETCH:
  - `imem_req` = 1 and `imem_addr` = `pc`; the request stays high with a stable address until `imem_ready`.
  - On `imem_ready`: `instr` <= `imem_rdata`, then go to EXEC.
  - `retire` is ignored in FETCH.
- EXEC:
  - `instr_valid` = 1 and `imem_req` = 0; `instr` is held constant.
  - `imem_ready` is ignored in EXEC.
  - On `retire`: `pc` <= next_pc, then go to FETCH.
- next_pc priority, highest first:
  1. `jr`: `{jr_target[N-1:2], 2'b00}`. The low bits are silently cleared.
  2. `jump` or `jal`: `{pc_plus4[N-1:28], instr[25:0], 2'b00}`.
  3. `branch & zero`: `pc_plus4 + (sext(instr[15:0]) << 2)`.
  4. Otherwise: `pc_plus4`.
- Arithmetic is modulo 2^N. PC `32'hFFFF_FFFC` + 4 wraps to 0 with no flag.
- When several control inputs are asserted together, the priority above resolves them. `branch` without `zero` falls through to `pc_plus4`.
- The `jal` link write is the register file's job; this block only exposes `pc_plus4`, which stays valid throughout EXEC.

## Timing
- Reset values: state = FETCH, `pc` = `RESET_PC`, `instr` = 0, `instr_valid` = 0, `imem_req` = 0.
  - `imem_req` is gated low during any cycle with `rst` high.
- First request is the cycle after `rst` falls, with `imem_addr` = `RESET_PC`.
- Minimum 2 cycles per instruction: 1 FETCH cycle with same-cycle `imem_ready`, plus 1 EXEC cycle with same-cycle `retire`.
  - Each extra cycle without `imem_ready` or `retire` adds one cycle.
- The new `pc` is visible the cycle after `retire`, on the same edge that `instr_valid` drops.
- Reset mid-fetch or mid-exec:
  - The next edge discards the outstanding request and any latched instruction.
  - Instruction memory must cancel any outstanding read on `rst`; a late `imem_ready` would be treated as valid data.
- No combinational path from `imem_rdata` to `opcode`/`funct`; decode fields come only from the registered `instr`.

## Structure
- Shared package `cpu_pkg` holds:
  - `fetch_state_t` enum {FETCH, EXEC}
  - `OPCODE_W` = 6, `FUNCT_W` = 6
  - field slice constants: opcode 31:26, funct 5:0, imm 15:0, jidx 25:0
  - default `RESET_PC`
- One combinational sub-module `next_pc_calc` implements the priority mux and the target arithmetic. Its inputs are `pc_plus4`, `instr`, the control bits, and `jr_target`.

## Test plan
- Reset, then `imem_ready` held high and `retire` every EXEC cycle with no control bits:
  - PC sequence 0, 4, 8, 12.
  - `imem_req` pulses on alternate cycles.
- Memory holds `imem_ready` low for 3 cycles at PC 0x10:
  - `imem_req` stays 1 and `imem_addr` stays 0x10 for all 4 cycles.
  - `instr_valid` rises only after `imem_ready`.
- Branch at PC 0x20 with imm 0xFFFE, `branch`=1, `zero`=1:
  - next `pc` = 0x1C.
  - With `zero`=0 instead: next `pc` = 0x24.
- `jal` at PC 0x1000_0040 with jidx 0x0000100:
  - `pc_plus4` = 0x1000_0044 during EXEC.
  - next `pc` = 0x1000_0400.
- `jr`=1, `jump`=1, `branch`=1, `zero`=1 together, `jr_target` = 0x0000_0203:
  - next `pc` = 0x0000_0200.
- `rst` asserted while stalled in EXEC at PC 0x80:
  - Next cycle: `pc` = `RESET_PC`, `instr_valid` = 0, `instr` = 0.
  - Fetch resumes at `RESET_PC` the cycle after `rst` falls.
